// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encodings,
// instruction field positions, next-PC source selection.
package instr_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  typedef enum logic [1:0] {
    NPC_SEQ   = 2'd0,
    NPC_REDIR = 2'd1,
    NPC_PEND  = 2'd2,
    NPC_DEFER = 2'd3
  } npc_sel_t;

  function automatic logic misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Next-PC selection for the fetch stage plus the redirect alignment check.
module instr_fetch_next_pc
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] pend_target,
  input  logic [31:0] defer_target,
  input  npc_sel_t    sel,
  output logic [31:0] pc_next,
  output logic        bad_align
);

  always_comb begin
    pc_next = pc + 32'd4;
    case (sel)
      NPC_REDIR: pc_next = redirect_pc;
      NPC_PEND:  pc_next = pend_target;
      NPC_DEFER: pc_next = defer_target;
      default:   pc_next = pc + 32'd4;
    endcase
  end

  assign bad_align = misaligned(redirect_pc[1:0]);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches over req/ack, holds the word in IR for decode.
// Optional MIPS delay-slot redirect behaviour is enabled with IFETCH_DELAY_SLOT_EN.
//
// state  | meaning
// S_IDLE | first cycle after reset, no request yet
// S_REQ  | request outstanding at pc, waiting for imem_ack
// S_HOLD | IR valid, waiting for decode handshake
// S_HALT | misaligned redirect seen, stopped until reset
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault
);

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, pc_next, ir, pc_out_r, pend_target;
  logic        redirect_pending, halt_pending;
  logic        pc_load, ir_load, fault_set, pend_set, pend_clr, halt_set;
  logic        bad_align, redir_eff, bad_redirect;
  npc_sel_t    npc_sel;
  logic        defer_pending;
  logic [31:0] defer_target;

`ifdef IFETCH_DELAY_SLOT_EN
  logic defer_set, defer_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      defer_pending <= 1'b0;
      defer_target  <= '0;
    end else begin
      if (defer_clr) defer_pending <= 1'b0;
      else if (defer_set) defer_pending <= 1'b1;
      if (defer_set) defer_target <= redirect_pc;
    end
  end
`else
  assign defer_pending = 1'b0;
  assign defer_target  = '0;
`endif

  // While a delay-slot target is held, further redirects are ignored.
  assign redir_eff    = redirect && !defer_pending;
  assign bad_redirect = redir_eff && bad_align;

  instr_fetch_next_pc u_next_pc (
    .pc           (pc),
    .redirect_pc  (redirect_pc),
    .pend_target  (pend_target),
    .defer_target (defer_target),
    .sel          (npc_sel),
    .pc_next      (pc_next),
    .bad_align    (bad_align)
  );

  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    npc_sel   = NPC_SEQ;
    ir_load   = 1'b0;
    fault_set = 1'b0;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    halt_set  = 1'b0;
`ifdef IFETCH_DELAY_SLOT_EN
    defer_set = 1'b0;
    defer_clr = 1'b0;
`endif
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          // The request cannot be cancelled, so a redirect drops the returning word.
          pend_clr = 1'b1;
          if (halt_pending || bad_redirect) begin
            fault_set = bad_redirect;
            state_nxt = S_HALT;
          end else if (redir_eff) begin
            pc_load = 1'b1;
            npc_sel = NPC_REDIR;
          end else if (redirect_pending) begin
            pc_load = 1'b1;
            npc_sel = NPC_PEND;
          end else begin
            ir_load   = 1'b1;
            state_nxt = S_HOLD;
          end
        end else if (!halt_pending) begin
          if (bad_redirect) begin
            fault_set = 1'b1;
            halt_set  = 1'b1;
          end else if (redir_eff) begin
            pend_set = 1'b1;
          end
        end
      end
      S_HOLD: begin
`ifdef IFETCH_DELAY_SLOT_EN
        if (defer_pending && out_ready) begin
          pc_load   = 1'b1;
          npc_sel   = NPC_DEFER;
          defer_clr = 1'b1;
          state_nxt = S_REQ;
        end else if (bad_redirect) begin
          fault_set = 1'b1;
          state_nxt = S_HALT;
        end else if (redir_eff && out_ready) begin
          pc_load   = 1'b1;
          defer_set = 1'b1;
          state_nxt = S_REQ;
        end else if (redir_eff) begin
          pc_load   = 1'b1;
          npc_sel   = NPC_REDIR;
          state_nxt = S_REQ;
        end else if (out_ready) begin
          pc_load   = 1'b1;
          state_nxt = S_REQ;
        end
`else
        if (bad_redirect) begin
          fault_set = 1'b1;
          state_nxt = S_HALT;
        end else if (redir_eff) begin
          pc_load   = 1'b1;
          npc_sel   = NPC_REDIR;
          state_nxt = S_REQ;
        end else if (out_ready) begin
          pc_load   = 1'b1;
          state_nxt = S_REQ;
        end
`endif
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      pc               <= RESET_PC;
      pc_out_r         <= RESET_PC;
      ir               <= '0;
      fault            <= 1'b0;
      redirect_pending <= 1'b0;
      pend_target      <= '0;
      halt_pending     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pc_load) pc <= pc_next;
      if (ir_load) begin
        ir       <= imem_rdata;
        pc_out_r <= pc;
      end
      if (fault_set) fault <= 1'b1;
      if (pend_clr) redirect_pending <= 1'b0;
      else if (pend_set) redirect_pending <= 1'b1;
      if (pend_set) pend_target <= redirect_pc;
      if (pend_clr) halt_pending <= 1'b0;
      else if (halt_set) halt_pending <= 1'b1;
    end
  end

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;
  assign out_valid = (state == S_HOLD);
  assign instr     = ir;
  assign op        = ir[OP_MSB:OP_LSB];
  assign funct     = ir[FUNCT_MSB:FUNCT_LSB];
  assign pc_out    = pc_out_r;
  assign pc_plus4  = pc_out_r + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed scoreboard bench for instr_fetch: a memory responder and decode sink
// run inside tick(); expected deliveries are queued before each scenario.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] instr, pc_out, pc_plus4;
  logic [5:0]  op, funct;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fault;

  logic        imem_req2, imem_ack2 = 1'b0, out_valid2, fault2;
  logic [31:0] imem_addr2, imem_rdata2 = '0, instr2, pc_out2, pc_plus4_2;
  logic [5:0]  op2, funct2;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .instr(instr), .op(op), .funct(funct),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .redirect(redirect),
    .redirect_pc(redirect_pc), .fault(fault)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .out_valid(out_valid2),
    .out_ready(1'b1), .instr(instr2), .op(op2), .funct(funct2),
    .pc_out(pc_out2), .pc_plus4(pc_plus4_2), .redirect(1'b0),
    .redirect_pc(32'h0), .fault(fault2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    int          t;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0, n_err = 0;
  int          tick_cnt = 0, mem_age = 0, hold_age = 0;
  int          ack_delay = 0, ready_delay = 0;
  logic [31:0] req_addr = '0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_tgt = '0;
  logic        ds_armed = 1'b0;
  logic [31:0] ds_pc = '0, ds_tgt = '0;
  logic [31:0] log2[2];
  int          n2 = 0;
  logic        seen2 = 1'b0;
  logic [31:0] pcout2_cap = '0, pcp4_2_cap = '0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0022_1820 : {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input int t);
    exp_t e;
    e.pc = pc;
    e.word = word_at(pc);
    e.t = t;
    sb.push_back(e);
  endtask

  task automatic tick();
    logic fire;
    fire = 1'b0;
    @(negedge clk);
    tick_cnt++;
    // Wrap-around instance: always-ready memory and decode.
    if (imem_req2 && n2 < 2) begin
      log2[n2] = imem_addr2;
      n2++;
    end
    imem_ack2   = imem_req2;
    imem_rdata2 = imem_addr2;
    if (out_valid2 && !seen2) begin
      seen2 = 1'b1;
      pcout2_cap = pc_out2;
      pcp4_2_cap = pc_plus4_2;
    end
    // Memory responder for the main instance.
    if (imem_ack) mem_age = 0;
    if (imem_req) begin
      if (mem_age == 0) req_addr = imem_addr;
      else check("addr_hold", imem_addr, req_addr);
      imem_ack   = (mem_age >= ack_delay);
      imem_rdata = word_at(imem_addr);
      mem_age++;
    end else begin
      imem_ack = 1'b0;
      mem_age  = 0;
    end
    // Decode sink: accepts only while a delivery is expected.
    if (out_valid && sb.size() != 0) begin
      check("ir_pc", pc_out, sb[0].pc);
      check("ir_word", instr, sb[0].word);
      out_ready = (hold_age >= ready_delay);
      hold_age++;
      if (out_ready) begin
        check("op", 32'(op), 32'(sb[0].word[31:26]));
        check("funct", 32'(funct), 32'(sb[0].word[5:0]));
        check("pc_plus4", pc_plus4, sb[0].pc + 32'd4);
        if (sb[0].t >= 0) check("valid_cycle", tick_cnt, sb[0].t);
        if (ds_armed && sb[0].pc == ds_pc) begin
          fire = 1'b1;
          ds_armed = 1'b0;
        end
        void'(sb.pop_front());
        hold_age = 0;
      end
    end else begin
      out_ready = 1'b0;
      hold_age  = 0;
    end
    redirect    = rd_req || fire;
    redirect_pc = fire ? ds_tgt : rd_tgt;
    rd_req      = 1'b0;
  endtask

  task automatic run_until_empty(input string tag, input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check(tag, sb.size(), 0);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr, input int budget);
    int k = 0;
    logic found = 1'b0;
    while (!found && k < budget) begin
      tick();
      k++;
      found = imem_req && imem_addr == addr;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    imem_ack = 1'b0;
    out_ready = 1'b0;
    redirect = 1'b0;
    rd_req = 1'b0;
    mem_age = 0;
    hold_age = 0;
    ack_delay = 0;
    ready_delay = 0;
    ds_armed = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick_cnt = 0;
  endtask

  initial begin
    // Back-to-back fetches with same-cycle acks: valid at cycles 2, 4, 6.
    do_reset();
    push(32'h0, 2);
    push(32'h4, 4);
    push(32'h8, 6);
    run_until_empty("drain_basic", 20);
    check("wrap_addr0", log2[0], 32'hFFFF_FFFC);
    check("wrap_addr1", log2[1], 32'h0000_0000);
    check("wrap_pc_out", pcout2_cap, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pcp4_2_cap, 32'h0000_0000);

    // Slow memory and slow decode: no skip, no duplicate.
    do_reset();
    ack_delay = 3;
    ready_delay = 5;
    push(32'h0, -1);
    push(32'h4, -1);
    push(32'h8, -1);
    run_until_empty("drain_slow", 80);

    // Redirect while the fetch of 0x8 is outstanding: that word is dropped.
    do_reset();
    ack_delay = 3;
    push(32'h0, -1);
    push(32'h4, -1);
    push(32'h40, -1);
    wait_req("wait_req_8", 32'h8, 40);
    rd_req = 1'b1;
    rd_tgt = 32'h40;
    run_until_empty("drain_redirect", 60);

    // Misaligned redirect during an outstanding request halts with fault.
    do_reset();
    ack_delay = 2;
    push(32'h0, -1);
    run_until_empty("drain_pre_fault", 20);
    wait_req("wait_req_4", 32'h4, 20);
    rd_req = 1'b1;
    rd_tgt = 32'h42;
    repeat (8) tick();
    check("halt_fault", 32'(fault), 32'd1);
    check("halt_req", 32'(imem_req), 32'd0);
    check("halt_valid", 32'(out_valid), 32'd0);
    do_reset();
    push(32'h0, -1);
    run_until_empty("drain_after_fault", 20);

    // Redirect coincident with the handshake of 0x10.
    do_reset();
    push(32'h0, -1);
    push(32'h4, -1);
    push(32'h8, -1);
    push(32'hC, -1);
    push(32'h10, -1);
`ifdef IFETCH_DELAY_SLOT_EN
    push(32'h14, -1);
`endif
    push(32'h100, -1);
    ds_armed = 1'b1;
    ds_pc = 32'h10;
    ds_tgt = 32'h100;
    run_until_empty("drain_branch", 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the main control decoder.
- Owns the PC and requests instructions from instruction memory over a req/ack handshake.
- Holds the fetched word in an instruction register (IR) and presents it to decode with valid/ready. Decode receives the op and funct fields from the IR.
- Accepts branch/jump redirects from the datapath.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request, held until imem_ack
- imem_addr  out  32  word-aligned fetch address; equals pc while imem_req=1
- imem_ack  in  1  memory response valid; imem_rdata is sampled this cycle
- imem_rdata  in  32  fetched instruction word
- out_valid  out  1  IR holds a valid instruction
- out_ready  in  1  decode accepts the instruction this cycle
- instr  out  32  IR contents
- op  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- pc_out  out  32  address of the instruction in the IR
- pc_plus4  out  32  pc_out + 4, used for link/branch base
- redirect  in  1  change control flow
- redirect_pc  in  32  redirect target
- fault  out  1  sticky misaligned-redirect flag

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: pc=RESET_PC, state=S_IDLE, imem_req=0, out_valid=0, instr=0, fault=0, redirect_pending=0.
- State machine:
  - S_IDLE -> S_REQ unconditionally on the first clock after rst_n deasserts.
  - S_REQ: imem_req=1, imem_addr=pc.
    - Stay in S_REQ while imem_ack=0.
    - On imem_ack: IR<=imem_rdata, pc_out<=pc, go to S_HOLD. out_valid rises the next cycle.
    - Ack in the same cycle as req is legal.
  - S_HOLD: out_valid=1; IR and pc_out are stable.
    - On out_valid&&out_ready: pc<=pc+4, go to S_REQ.
  - S_HALT: imem_req=0, out_valid=0. Exit only by reset.
- Timing: ack in cycle N gives out_valid=1 in cycle N+1. Best-case throughput is 1 instruction per 2 cycles.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Redirects (without the optional feature):
  - In S_HOLD, with or without handshake: IR is discarded (out_valid=0 next cycle), pc<=redirect_pc, go to S_REQ.
  - In S_REQ before ack: imem_req stays high at the old address; the request cannot be cancelled. Set redirect_pending and latch the target. When the ack arrives, drop the data, load pc<=target, clear redirect_pending, and re-enter S_REQ. out_valid never asserts for the dropped word.
  - Redirect and ack in the same cycle: the data is dropped and the next request goes to redirect_pc.
  - Back-to-back redirects: the latest target wins.
- Misaligned redirect: redirect with redirect_pc[1:0]!=0 sets fault=1 (sticky) and goes to S_HALT. If a request is outstanding, wait for ack, discard it, then halt.
- Reset mid-fetch: all state clears immediately. A late imem_ack after reset is ignored because state is S_IDLE.
- out_ready while out_valid=0 is a don't-care.

Optional Feature:
- Macro: IFETCH_DELAY_SLOT_EN.
- Defined (MIPS branch delay slot): a redirect coincident with the out_valid&&out_ready handshake of the instruction at X is deferred.
  - The next fetch is X+4 (the delay slot), delivered normally.
  - On the delay slot's handshake, pc<=saved target.
  - A redirect arriving while a deferred target is held is ignored.
  - Redirects not coincident with a handshake behave as when the macro is undefined.
- Undefined: every redirect takes effect immediately as above; there is no delay-slot register.

Decomposition:
- ifetch_defs.v (header, `include style): state encodings S_IDLE/S_REQ/S_HOLD/S_HALT, OP_MSB/OP_LSB/FUNCT_MSB/FUNCT_LSB field positions, default RESET_PC.
- Sub-module ifetch_next_pc (combinational): selects pc+4, redirect_pc, latched target, or deferred target. Also produces the misalignment check.

Test Plan:
- Reset release, memory acks same cycle: out_valid at cycles 2, 4, 6 with pc_out 0x0, 0x4, 0x8. instr=0x00221820 gives op=0x00, funct=0x20.
- Ack delayed 3 cycles, out_ready held low 5 cycles: imem_req held at the same address throughout; IR and pc_out stable; one instruction delivered; no skip or duplicate.
- Redirect to 0x40 during S_REQ for 0x8, ack 2 cycles later: word from 0x8 never valid; next request at 0x40; pc_out=0x40.
- RESET_PC=32'hFFFF_FFFC: second fetch address is 0x0000_0000.
- Redirect to 0x42: fault=1; imem_req=0 and out_valid=0 until rst_n pulse, then fetch resumes at RESET_PC.
- IFETCH_DELAY_SLOT_EN defined, redirect to 0x100 on handshake of 0x10: delivered sequence is 0x10, 0x14, 0x100.
